// File: rtl/estacao_reserva_r_pkg.sv
// Shared encodings and helpers for the R-type reservation station.
// OLDEST_FIRST_EN (optional) enables age-ordered dispatch using AGE_W-bit ranks.
package estacao_reserva_r_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int TAG_W_DEF  = 3;
    localparam int TAG_NONE   = 0;
    localparam int AGE_W      = 3;

    typedef enum logic [2:0] {
        UF_ADD = 3'b000,
        UF_SUB = 3'b001,
        UF_SLT = 3'b010,
        UF_CMP = 3'b011,
        UF_BP4 = 3'b100,
        UF_BM4 = 3'b101
    } ufop_e;

    typedef struct packed {
        logic       busy;
        logic [2:0] op;
    } rs_hdr_t;

    // B+4 and B-4 only consume operand B, so a pending Qj must not stall them.
    function automatic logic op_ignores_qj(input logic [2:0] op);
        return (op == UF_BP4) || (op == UF_BM4);
    endfunction

    function automatic logic op_illegal(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    // Ranks count older busy entries, so a smaller rank is older.
    function automatic logic age_older(input logic [AGE_W-1:0] a, input logic [AGE_W-1:0] b);
        return a < b;
    endfunction

endpackage

// File: rtl/estacao_reserva_r_sel.sv
// Dispatch selector: ready mask (plus ranks when OLDEST_FIRST_EN) to one-hot grant.
// Without OLDEST_FIRST_EN the lowest-index ready entry wins.
module estacao_reserva_r_sel
    import estacao_reserva_r_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]            ready_i,
`ifdef OLDEST_FIRST_EN
    input  logic [N-1:0][AGE_W-1:0] age_i,
`endif
    output logic [N-1:0]            grant_o,
    output logic                    valid_o
);

    assign valid_o = |ready_i;

`ifdef OLDEST_FIRST_EN
    logic             found;
    logic [AGE_W-1:0] best_age;

    always_comb begin
        grant_o  = '0;
        found    = 1'b0;
        best_age = '0;
        for (int i = 0; i < N; i++) begin
            if (ready_i[i] && (!found || age_older(age_i[i], best_age))) begin
                grant_o    = '0;
                grant_o[i] = 1'b1;
                found      = 1'b1;
                best_age   = age_i[i];
            end
        end
    end
`else
    assign grant_o = ready_i & (~ready_i + N'(1));
`endif

endmodule

// File: rtl/estacao_reserva_r.sv
// Reservation station for the combinational R-type unit: issue, CDB snoop, dispatch, result hold.
// OLDEST_FIRST_EN (optional) keeps per-entry age ranks and dispatches the oldest ready entry.
module estacao_reserva_r
    import estacao_reserva_r_pkg::*;
#(
    parameter int NUM_ENTRIES = 3,
    parameter int TAG_W       = TAG_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int RS_BASE_TAG = 1
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [2:0]        issue_op,
    input  logic [DATA_W-1:0] issue_vj,
    input  logic [DATA_W-1:0] issue_vk,
    input  logic [TAG_W-1:0]  issue_qj,
    input  logic [TAG_W-1:0]  issue_qk,
    output logic [TAG_W-1:0]  issue_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic [DATA_W-1:0] fu_A,
    output logic [DATA_W-1:0] fu_B,
    output logic [2:0]        fu_Ufop,
    input  logic [DATA_W-1:0] fu_Q,
    output logic              res_valid,
    output logic [TAG_W-1:0]  res_tag,
    output logic [DATA_W-1:0] res_data,
    input  logic              res_ready,
    output logic [2:0]        busy_count
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam logic [TAG_W-1:0] TAG_Z = TAG_W'(TAG_NONE);

    rs_hdr_t           hdr_q [NUM_ENTRIES];
    rs_hdr_t           hdr_d [NUM_ENTRIES];
    logic [DATA_W-1:0] vj_q  [NUM_ENTRIES];
    logic [DATA_W-1:0] vj_d  [NUM_ENTRIES];
    logic [DATA_W-1:0] vk_q  [NUM_ENTRIES];
    logic [DATA_W-1:0] vk_d  [NUM_ENTRIES];
    logic [TAG_W-1:0]  qj_q  [NUM_ENTRIES];
    logic [TAG_W-1:0]  qj_d  [NUM_ENTRIES];
    logic [TAG_W-1:0]  qk_q  [NUM_ENTRIES];
    logic [TAG_W-1:0]  qk_d  [NUM_ENTRIES];
`ifdef OLDEST_FIRST_EN
    logic [NUM_ENTRIES-1:0][AGE_W-1:0] age_q, age_d;
`endif

    logic              res_valid_q, res_valid_d;
    logic [TAG_W-1:0]  res_tag_q, res_tag_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [DATA_W-1:0] fu_a_q, fu_a_d;
    logic [DATA_W-1:0] fu_b_q, fu_b_d;
    logic [2:0]        fu_op_q, fu_op_d;

    logic [NUM_ENTRIES-1:0] busy_vec, ready_vec, grant;
    logic                   grant_valid, disp_fire, issue_fire, free_found;
    logic [IDX_W-1:0]       free_idx, grant_idx;
    logic [2:0]             busy_cnt;
    logic                   byp_j, byp_k;
    logic [DATA_W-1:0]      new_vj, new_vk;
    logic [TAG_W-1:0]       new_qj, new_qk;

    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        busy_cnt  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            busy_vec[i]  = hdr_q[i].busy;
            ready_vec[i] = hdr_q[i].busy && (qk_q[i] == TAG_Z) &&
                           (op_ignores_qj(hdr_q[i].op) || (qj_q[i] == TAG_Z));
            busy_cnt     = busy_cnt + 3'(hdr_q[i].busy);
        end
    end

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!busy_vec[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    estacao_reserva_r_sel #(.N(NUM_ENTRIES)) u_sel (
        .ready_i (ready_vec),
`ifdef OLDEST_FIRST_EN
        .age_i   (age_q),
`endif
        .grant_o (grant),
        .valid_o (grant_valid)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (grant[i]) grant_idx = IDX_W'(i);
        end
    end

    // issue_ready looks only at registered Busy, so a slot freed by dispatch reopens next cycle.
    assign issue_ready = free_found;
    assign issue_fire  = issue_valid && free_found;
    assign issue_tag   = TAG_W'(RS_BASE_TAG) + TAG_W'(free_idx);
    assign disp_fire   = grant_valid && (!res_valid_q || res_ready);

    assign byp_j  = cdb_valid && (issue_qj != TAG_Z) && (cdb_tag == issue_qj);
    assign byp_k  = cdb_valid && (issue_qk != TAG_Z) && (cdb_tag == issue_qk);
    assign new_vj = byp_j ? cdb_data : issue_vj;
    assign new_vk = byp_k ? cdb_data : issue_vk;
    assign new_qj = byp_j ? TAG_Z : issue_qj;
    assign new_qk = byp_k ? TAG_Z : issue_qk;

    assign fu_A    = disp_fire ? vj_q[grant_idx]     : fu_a_q;
    assign fu_B    = disp_fire ? vk_q[grant_idx]     : fu_b_q;
    assign fu_Ufop = disp_fire ? hdr_q[grant_idx].op : fu_op_q;

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            hdr_d[i] = hdr_q[i];
            vj_d[i]  = vj_q[i];
            vk_d[i]  = vk_q[i];
            qj_d[i]  = qj_q[i];
            qk_d[i]  = qk_q[i];
        end
`ifdef OLDEST_FIRST_EN
        age_d = age_q;
`endif
        res_valid_d = res_valid_q;
        res_tag_d   = res_tag_q;
        res_data_d  = res_data_q;
        fu_a_d      = fu_a_q;
        fu_b_d      = fu_b_q;
        fu_op_d     = fu_op_q;

        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (hdr_q[i].busy && cdb_valid && (cdb_tag != TAG_Z)) begin
                if (qj_q[i] == cdb_tag) begin
                    vj_d[i] = cdb_data;
                    qj_d[i] = TAG_Z;
                end
                if (qk_q[i] == cdb_tag) begin
                    vk_d[i] = cdb_data;
                    qk_d[i] = TAG_Z;
                end
            end
`ifdef OLDEST_FIRST_EN
            // Entries younger than the departing one move up one rank.
            if (disp_fire && (age_q[i] > age_q[grant_idx])) begin
                age_d[i] = age_q[i] - AGE_W'(1);
            end
`endif
            if (disp_fire && grant[i]) begin
                hdr_d[i].busy = 1'b0;
            end
            if (issue_fire && (free_idx == IDX_W'(i))) begin
                hdr_d[i].busy = 1'b1;
                hdr_d[i].op   = issue_op;
                vj_d[i]       = new_vj;
                vk_d[i]       = new_vk;
                qj_d[i]       = new_qj;
                qk_d[i]       = new_qk;
`ifdef OLDEST_FIRST_EN
                age_d[i]      = AGE_W'(busy_cnt) - AGE_W'(disp_fire);
`endif
            end
        end

        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
        if (disp_fire) begin
            res_valid_d = 1'b1;
            res_tag_d   = TAG_W'(RS_BASE_TAG) + TAG_W'(grant_idx);
            res_data_d  = op_illegal(hdr_q[grant_idx].op) ? '0 : fu_Q;
            fu_a_d      = vj_q[grant_idx];
            fu_b_d      = vk_q[grant_idx];
            fu_op_d     = hdr_q[grant_idx].op;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                hdr_q[i] <= '0;
                vj_q[i]  <= '0;
                vk_q[i]  <= '0;
                qj_q[i]  <= '0;
                qk_q[i]  <= '0;
            end
`ifdef OLDEST_FIRST_EN
            age_q       <= '0;
`endif
            res_valid_q <= 1'b0;
            res_tag_q   <= '0;
            res_data_q  <= '0;
            fu_a_q      <= '0;
            fu_b_q      <= '0;
            fu_op_q     <= '0;
        end else begin
            hdr_q       <= hdr_d;
            vj_q        <= vj_d;
            vk_q        <= vk_d;
            qj_q        <= qj_d;
            qk_q        <= qk_d;
`ifdef OLDEST_FIRST_EN
            age_q       <= age_d;
`endif
            res_valid_q <= res_valid_d;
            res_tag_q   <= res_tag_d;
            res_data_q  <= res_data_d;
            fu_a_q      <= fu_a_d;
            fu_b_q      <= fu_b_d;
            fu_op_q     <= fu_op_d;
        end
    end

    assign res_valid  = res_valid_q;
    assign res_tag    = res_tag_q;
    assign res_data   = res_data_q;
    assign busy_count = busy_cnt;

endmodule

// File: tb/tb_estacao_reserva_r.sv
// Self-checking bench for estacao_reserva_r: directed vectors, corner sequences, random vs. model.
// Expected dispatch order follows OLDEST_FIRST_EN when it is defined.
module tb_estacao_reserva_r;

    localparam int NE   = 3;
    localparam int BASE = 1;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        issue_valid, issue_ready;
    logic [2:0]  issue_op;
    logic [15:0] issue_vj, issue_vk;
    logic [2:0]  issue_qj, issue_qk, issue_tag;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic [15:0] fu_A, fu_B, fu_Q;
    logic [2:0]  fu_Ufop;
    logic        res_valid, res_ready;
    logic [2:0]  res_tag;
    logic [15:0] res_data;
    logic [2:0]  busy_count;

    always #5 Clock = ~Clock;

    // Stand-in for the R-type unit; illegal codes return junk the station must suppress.
    function automatic logic [15:0] fu_model(input logic [15:0] a, input logic [15:0] b,
                                             input logic [2:0] op);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return (a < b) ? 16'd1 : 16'd0;
            3'b011:  return (a == b) ? 16'd1 : 16'd0;
            3'b100:  return b + 16'd4;
            3'b101:  return b - 16'd4;
            default: return 16'hDEAD;
        endcase
    endfunction

    assign fu_Q = fu_model(fu_A, fu_B, fu_Ufop);

    estacao_reserva_r dut (
        .Clock(Clock), .Resetn(Resetn),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_qj(issue_qj), .issue_qk(issue_qk),
        .issue_tag(issue_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .fu_A(fu_A), .fu_B(fu_B), .fu_Ufop(fu_Ufop), .fu_Q(fu_Q),
        .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data), .res_ready(res_ready),
        .busy_count(busy_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_in();
        issue_valid = 0; issue_op = 0; issue_vj = 0; issue_vk = 0; issue_qj = 0; issue_qk = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_data = 0; res_ready = 0;
    endtask

    task automatic put(input logic [2:0] op, input logic [15:0] vj, input logic [15:0] vk,
                       input logic [2:0] qj, input logic [2:0] qk);
        issue_valid = 1; issue_op = op; issue_vj = vj; issue_vk = vk; issue_qj = qj; issue_qk = qk;
    endtask

    task automatic cdb(input logic [2:0] t, input logic [15:0] d);
        cdb_valid = 1; cdb_tag = t; cdb_data = d;
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        bit          busy;
        logic [2:0]  op;
        logic [15:0] vj, vk;
        logic [2:0]  qj, qk;
        int unsigned seq;
    } ment_t;

    ment_t       m [NE];
    bit          m_rv;
    logic [2:0]  m_rt, m_fo;
    logic [15:0] m_rd, m_fa, m_fb;
    int unsigned m_seq;
    bit          e_disp, e_ifire;
    int          e_didx, e_fidx;

    task automatic model_clear();
        for (int i = 0; i < NE; i++) m[i] = '{0, 0, 0, 0, 0, 0, 0};
        m_rv = 0; m_rt = 0; m_rd = 0; m_fa = 0; m_fb = 0; m_fo = 0; m_seq = 0;
    endtask

    function automatic bit m_ready(input int i);
        return m[i].busy && m[i].qk == 0 && (m[i].op == 3'd4 || m[i].op == 3'd5 || m[i].qj == 0);
    endfunction

    function automatic int m_free();
        for (int i = 0; i < NE; i++) if (!m[i].busy) return i;
        return -1;
    endfunction

    task automatic model_eval();
        int cnt;
        int di;
        logic [15:0] ea, eb;
        logic [2:0]  eo;
        e_fidx  = m_free();
        e_ifire = issue_valid && (e_fidx >= 0);
        di = -1;
        cnt = 0;
        for (int i = 0; i < NE; i++) begin
            if (m[i].busy) cnt++;
            if (m_ready(i)) begin
`ifdef OLDEST_FIRST_EN
                if (di < 0 || m[i].seq < m[di].seq) di = i;
`else
                if (di < 0) di = i;
`endif
            end
        end
        e_didx = di;
        e_disp = (di >= 0) && (!m_rv || res_ready);
        ea = e_disp ? m[di].vj : m_fa;
        eb = e_disp ? m[di].vk : m_fb;
        eo = e_disp ? m[di].op : m_fo;
        chk("issue_ready", issue_ready, (e_fidx >= 0));
        chk("busy_count", busy_count, cnt);
        chk("res_valid", res_valid, m_rv);
        if (m_rv) begin
            chk("res_tag", res_tag, m_rt);
            chk("res_data", res_data, m_rd);
        end
        if (e_ifire) chk("issue_tag", issue_tag, BASE + e_fidx);
        chk("fu_A", fu_A, ea);
        chk("fu_B", fu_B, eb);
        chk("fu_Ufop", fu_Ufop, eo);
    endtask

    task automatic model_update();
        logic [15:0] r;
        r = 0;
        if (e_disp) begin
            r = (m[e_didx].op >= 3'd6) ? 16'h0 : fu_model(m[e_didx].vj, m[e_didx].vk, m[e_didx].op);
            m_fa = m[e_didx].vj; m_fb = m[e_didx].vk; m_fo = m[e_didx].op;
        end
        if (cdb_valid && cdb_tag != 0) begin
            for (int i = 0; i < NE; i++) begin
                if (m[i].busy && m[i].qj == cdb_tag) begin m[i].vj = cdb_data; m[i].qj = 0; end
                if (m[i].busy && m[i].qk == cdb_tag) begin m[i].vk = cdb_data; m[i].qk = 0; end
            end
        end
        if (e_disp) begin
            m[e_didx].busy = 0;
            m_rv = 1; m_rt = 3'(BASE + e_didx); m_rd = r;
        end else if (m_rv && res_ready) begin
            m_rv = 0;
        end
        if (e_ifire) begin
            m[e_fidx].busy = 1;
            m[e_fidx].op   = issue_op;
            m[e_fidx].vj   = issue_vj;
            m[e_fidx].vk   = issue_vk;
            m[e_fidx].qj   = issue_qj;
            m[e_fidx].qk   = issue_qk;
            if (cdb_valid && issue_qj != 0 && cdb_tag == issue_qj) begin
                m[e_fidx].vj = cdb_data; m[e_fidx].qj = 0;
            end
            if (cdb_valid && issue_qk != 0 && cdb_tag == issue_qk) begin
                m[e_fidx].vk = cdb_data; m[e_fidx].qk = 0;
            end
            m[e_fidx].seq = m_seq;
            m_seq++;
        end
    endtask

    task automatic do_reset();
        idle_in();
        Resetn = 0;
        repeat (2) @(posedge Clock);
        #1 Resetn = 1;
        model_clear();
        tick();
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [2:0]  op;
        logic [15:0] vj, vk, res;
    } vec_t;

    vec_t vt [10];
    logic [2:0] drain_tag [3];
    logic [2:0] first_tag, second_tag;
    logic [15:0] first_dat, second_dat;

    initial begin
        vt[0] = '{3'b000, 16'd5,     16'd7, 16'd12};
        vt[1] = '{3'b001, 16'd3,     16'd5, 16'hFFFE};
        vt[2] = '{3'b010, 16'd3,     16'd9, 16'd1};
        vt[3] = '{3'b010, 16'd9,     16'd3, 16'd0};
        vt[4] = '{3'b010, 16'h8000,  16'd1, 16'd0};
        vt[5] = '{3'b100, 16'd999,   16'd0, 16'd4};
        vt[6] = '{3'b101, 16'd0,     16'd2, 16'hFFFE};
        vt[7] = '{3'b110, 16'd1,     16'd2, 16'd0};
        vt[8] = '{3'b111, 16'd5,     16'd5, 16'd0};
        vt[9] = '{3'b000, 16'hFFFF,  16'd1, 16'd0};
`ifdef OLDEST_FIRST_EN
        drain_tag[0] = 3'd2; drain_tag[1] = 3'd1; drain_tag[2] = 3'd3;
        first_tag = 3'd3; first_dat = 16'd110; second_tag = 3'd1; second_dat = 16'd120;
`else
        drain_tag[0] = 3'd1; drain_tag[1] = 3'd2; drain_tag[2] = 3'd3;
        first_tag = 3'd1; first_dat = 16'd120; second_tag = 3'd3; second_dat = 16'd110;
`endif

        idle_in();
        Resetn = 0;
        #2;
        chk("rst issue_ready", issue_ready, 1);
        chk("rst res_valid", res_valid, 0);
        chk("rst busy_count", busy_count, 0);
        chk("rst fu_A", fu_A, 0);
        chk("rst res_tag", res_tag, 0);
        do_reset();

        for (int k = 0; k < 10; k++) begin
            put(vt[k].op, vt[k].vj, vt[k].vk, 0, 0);
            chk("vec issue_tag", issue_tag, 1);
            tick();
            issue_valid = 0;
            chk("vec fu_A", fu_A, vt[k].vj);
            chk("vec fu_Ufop", fu_Ufop, vt[k].op);
            chk("vec res_valid early", res_valid, 0);
            tick();
            chk("vec res_valid", res_valid, 1);
            chk("vec res_tag", res_tag, 1);
            chk("vec res_data", res_data, vt[k].res);
            res_ready = 1;
            tick();
            res_ready = 0;
            chk("vec drained", res_valid, 0);
            chk("vec fu_B hold", fu_B, vt[k].vk);
        end

        // Snoop: sub waits on tag 3, released by the CDB.
        put(3'b001, 16'd20, 16'd0, 0, 3'd3);
        tick();
        issue_valid = 0;
        tick();
        chk("snoop wait", res_valid, 0);
        cdb(3'd3, 16'd8);
        tick();
        cdb_valid = 0;
        chk("snoop not yet", res_valid, 0);
        tick();
        chk("snoop res_valid", res_valid, 1);
        chk("snoop res_data", res_data, 12);
        chk("snoop res_tag", res_tag, 1);
        res_ready = 1; tick(); res_ready = 0;

        // Bypass: Qj matched by the CDB in the issue cycle.
        put(3'b010, 16'h77, 16'd9, 3'd2, 0);
        cdb(3'd2, 16'd3);
        tick();
        issue_valid = 0; cdb_valid = 0;
        tick();
        chk("bypass res_valid", res_valid, 1);
        chk("bypass res_data", res_data, 1);
        res_ready = 1; tick(); res_ready = 0;

        // Full and backpressure with B+4 ops whose Qj is pending (must be ignored).
        put(3'b100, 16'h1111, 16'd0, 3'd6, 0);
        chk("full tag0", issue_tag, 1);
        tick();
        put(3'b100, 16'h2222, 16'd0, 3'd6, 0);
        chk("full tag1", issue_tag, 2);
        tick();
        chk("full first res_valid", res_valid, 1);
        chk("full first res_tag", res_tag, 1);
        chk("full first res_data", res_data, 4);
        put(3'b100, 16'h3333, 16'd0, 3'd6, 0);
        chk("full tag2", issue_tag, 1);
        tick();
        put(3'b100, 16'h4444, 16'd0, 3'd6, 0);
        chk("full tag3", issue_tag, 3);
        tick();
        put(3'b000, 16'd1, 16'd1, 0, 0);
        chk("full issue_ready", issue_ready, 0);
        chk("full busy_count", busy_count, 3);
        tick();
        issue_valid = 0;
        chk("full ignored", busy_count, 3);
        chk("hold res_tag", res_tag, 1);
        chk("hold res_data", res_data, 4);
        res_ready = 1; tick(); res_ready = 0;
        for (int k = 0; k < 3; k++) begin
            chk("drain res_valid", res_valid, 1);
            chk("drain res_tag", res_tag, drain_tag[k]);
            chk("drain res_data", res_data, 4);
            tick();
            chk("drain stable", res_tag, drain_tag[k]);
            res_ready = 1; tick(); res_ready = 0;
        end
        chk("drain empty", res_valid, 0);
        chk("drain busy_count", busy_count, 0);
        chk("drain issue_ready", issue_ready, 1);

        // Dispatch order: entry 2 older than a later-issued entry 0, both woken by tag 7.
        res_ready = 1;
        put(3'b000, 16'd1, 16'd0, 0, 3'd5); tick();
        put(3'b000, 16'd2, 16'd0, 0, 3'd6); tick();
        put(3'b000, 16'd10, 16'd0, 0, 3'd7);
        chk("order tag3", issue_tag, 3);
        tick();
        issue_valid = 0;
        cdb(3'd5, 16'd2); tick();
        cdb(3'd6, 16'd3); tick();
        cdb_valid = 0;
        chk("order r1 tag", res_tag, 1);
        chk("order r1 data", res_data, 3);
        tick();
        chk("order r2 tag", res_tag, 2);
        chk("order r2 data", res_data, 5);
        put(3'b000, 16'd20, 16'd0, 0, 3'd7);
        chk("order reissue tag", issue_tag, 1);
        tick();
        issue_valid = 0;
        cdb(3'd7, 16'd100); tick();
        cdb_valid = 0;
        tick();
        chk("order first tag", res_tag, first_tag);
        chk("order first data", res_data, first_dat);
        tick();
        chk("order second tag", res_tag, second_tag);
        chk("order second data", res_data, second_dat);
        tick();
        chk("order done", res_valid, 0);
        res_ready = 0;

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            int fi;
            fi = m_free();
            issue_valid = ($urandom_range(0, 2) != 0);
            issue_op = 3'($urandom_range(0, 7));
            issue_vj = 16'($urandom);
            issue_vk = 16'($urandom);
            issue_qj = $urandom_range(0, 1) ? 3'd0 : 3'($urandom_range(1, 7));
            issue_qk = $urandom_range(0, 1) ? 3'd0 : 3'($urandom_range(1, 7));
            if (fi >= 0 && issue_qj == 3'(BASE + fi)) issue_qj = 0;
            if (fi >= 0 && issue_qk == 3'(BASE + fi)) issue_qk = 0;
            res_ready = ($urandom_range(0, 3) != 0);
            if (m_rv && res_ready && $urandom_range(0, 1) == 1) begin
                cdb(m_rt, m_rd);
            end else begin
                cdb_valid = $urandom_range(0, 1);
                cdb_tag   = 3'($urandom_range(0, 7));
                cdb_data  = 16'($urandom);
            end
            @(negedge Clock);
            model_eval();
            @(posedge Clock);
            model_update();
            #1;
        end

        // Asynchronous reset with work in flight.
        idle_in();
        put(3'b000, 16'd3, 16'd4, 0, 0);
        repeat (3) tick();
        issue_valid = 0;
        #2 Resetn = 0;
        #1;
        chk("areset res_valid", res_valid, 0);
        chk("areset res_tag", res_tag, 0);
        chk("areset res_data", res_data, 0);
        chk("areset busy_count", busy_count, 0);
        chk("areset fu_A", fu_A, 0);
        chk("areset fu_B", fu_B, 0);
        chk("areset fu_Ufop", fu_Ufop, 0);
        chk("areset issue_ready", issue_ready, 1);
        @(posedge Clock);
        #1 Resetn = 1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/estacao_reserva_r.md
Name: estacao_reserva_r

Overview:
Reservation station feeding the combinational R-type functional unit (Ufop: 000 add, 001 sub, 010 slt, 011 cmp, 100 B+4, 101 B-4) in the Tomasulo datapath. It accepts issued instructions with tagged operands and snoops the CDB for pending values. It drives A/B/Ufop to the unit for one ready entry, then holds the registered result until the CDB arbiter grants broadcast.

Parameters:
NUM_ENTRIES, 3, reservation station slots (2..7)
TAG_W, 3, width of producer tags; tag 0 = value present
DATA_W, 16, operand/result width
RS_BASE_TAG, 1, tag of entry 0; entry i owns tag RS_BASE_TAG+i

Ports:
Clock  in  1  single clock, rising edge
Resetn  in  1  asynchronous, active-low reset
issue_valid  in  1  issue unit offers an instruction
issue_ready  out  1  a free entry exists (registered state only)
issue_op  in  3  Ufop code
issue_vj / issue_vk  in  DATA_W  operand values
issue_qj / issue_qk  in  TAG_W  producer tags (0 = value valid)
issue_tag  out  TAG_W  tag allocated to the accepted instruction (valid with handshake)
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  broadcasting producer tag
cdb_data  in  DATA_W  broadcast value
fu_A / fu_B  out  DATA_W  operands to the functional unit
fu_Ufop  out  3  operation to the functional unit
fu_Q  in  DATA_W  combinational unit result
res_valid  out  1  result pending for CDB
res_tag  out  TAG_W  tag of pending result
res_data  out  DATA_W  pending result
res_ready  in  1  CDB grant; result consumed this cycle
busy_count  out  3  number of occupied entries

Behaviour:
- Reset (async, Resetn=0): all Busy=0, res_valid=0, res_tag=0, res_data=0, busy_count=0, fu_A/fu_B=0, fu_Ufop=000, issue_ready=1. In-flight entries and pending result are discarded.
- Entry fields: Busy, Op, Vj, Vk, Qj, Qk. An entry is ready when Busy and Qj==0 and Qk==0. Ops 100/101 ignore Qj, so only Qk must be 0.
- Issue: accepted on issue_valid&&issue_ready and written to the lowest-index free entry; issue_tag = RS_BASE_TAG+index, combinationally.
  - If cdb_valid and cdb_tag matches a nonzero issue_qj/qk in the same cycle, cdb_data is captured and Q is stored as 0 (same-cycle bypass).
- Snoop: every Busy entry with Qj (or Qk) == cdb_tag != 0 and cdb_valid loads Vj (Vk) and clears the tag. cdb_tag 0 is ignored.
- Dispatch: allowed when any entry is ready and the result register is free (!res_valid, or res_valid&&res_ready).
  - The selected entry drives fu_A=Vj, fu_B=Vk, fu_Ufop=Op.
  - On the same edge: res_data<=fu_Q, res_tag<=entry tag, res_valid<=1, Busy<=0.
  - Latency: entry ready -> res_valid on the next edge (1 cycle).
  - When not dispatching, fu_* hold their last values.
- Illegal ops 110/111: accepted, result forced to 0.
- An entry freed by dispatch is not re-allocatable until the next cycle, because issue_ready uses registered Busy.
- Result handshake: res_* are stable while res_valid&&!res_ready. Back-to-back dispatch is allowed on the grant cycle.
- Full: issue_ready=0 when all NUM_ENTRIES are Busy; issue_valid is then ignored.
- Own result re-entering via cdb_* is snooped like any other tag. An entry waiting on its own tag is impossible and needs no check.
- Arithmetic is modulo 2^DATA_W; slt is unsigned.

Optional Feature:
OLDEST_FIRST_EN
- Defined: each entry stores an age stamp from a wrap-safe issue counter; dispatch selects the oldest ready entry.
- Undefined: dispatch selects the lowest-index ready entry; no age storage is synthesized.

Decomposition:
- Shared package: Ufop encodings, TAG_NONE=0, DATA_W/TAG_W defaults, entry struct typedef.
- The existing R-type functional unit is instantiated unchanged.
- One natural new sub-module: estacao_reserva_r_sel (ready mask [+ ages] -> one-hot grant + valid).

Test Plan:
- Reset mid-op: entries busy, res_valid=1, pull Resetn low asynchronously -> all outputs 0 immediately, issue_ready=1.
- Ready issue: op 000, Vj=5, Vk=7, tags 0 -> res_valid the next cycle, res_data=12, res_tag=1.
- Snoop wait: op 001, Vj=20, qk=3; later cdb tag 3 data 8 -> dispatch the next cycle, res_data=12.
- Bypass: issue op 010 with qj=2 while cdb tag 2 data 3, Vk=9 -> entry ready immediately, res_data=1.
- Full/backpressure: fill 3 entries with res_ready=0 -> issue_ready=0, res held stable; single res_ready pulses drain one result per grant, and ops 100 with Vk=0 give 4.
- OLDEST_FIRST_EN: issue to entry 2 first and entry 0 later, both made ready in the same cycle -> entry 2 tag dispatched first (lowest-index entry 0 first without the macro).
